// File: rtl/snes_pad_poller.sv
// rtl/snes_pad_poller.sv - SNES pad serial poller
// Periodically latches the pad, clocks in 16 serial bits and publishes buttons/ID atomically.
module snes_pad_poller #(
   parameter int LATCH_CYC   = 600,
   parameter int HALF_CYC    = 300,
   parameter int POLL_PERIOD = 833333
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        poll_en,
   input  logic        snes_data,
   output logic        snes_latch,
   output logic        snes_clk,
   output logic [11:0] snes_button,
   output logic [3:0]  snes_id,
   output logic        frame_done,
   output logic        busy
);

   localparam int PW     = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int HW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
   localparam logic [HW-1:0] LATCH_LAST  = HW'(LATCH_CYC - 1);
   localparam logic [HW-1:0] HALF_LAST   = HW'(HALF_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      LOW,
      HIGH
   } state_t;

   state_t        state;
   logic [PW-1:0] period_cnt;
   logic [HW-1:0] phase_cnt;
   logic [3:0]    bit_cnt;
   logic [15:0]   shift;
   logic          sync1;
   logic          data_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         period_cnt  <= '0;
         phase_cnt   <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         sync1       <= 1'b1;
         data_s      <= 1'b1;
         snes_latch  <= 1'b0;
         snes_clk    <= 1'b1;
         snes_button <= '0;
         snes_id     <= '0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         sync1      <= snes_data;
         data_s     <= sync1;
         frame_done <= 1'b0;

         // Free-running frame timebase; poll_en only gates frame starts at its wrap
         if (period_cnt == PERIOD_LAST)
            period_cnt <= '0;
         else
            period_cnt <= period_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (period_cnt == '0 && poll_en) begin
                  state      <= LATCH;
                  snes_latch <= 1'b1;
                  busy       <= 1'b1;
                  phase_cnt  <= '0;
               end
            end
            LATCH: begin
               if (phase_cnt == LATCH_LAST) begin
                  state      <= LOW;
                  snes_latch <= 1'b0;
                  snes_clk   <= 1'b0;
                  phase_cnt  <= '0;
                  bit_cnt    <= '0;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            LOW: begin
               // Sample as late as possible in the low half so the pad's output has settled
               if (phase_cnt == HALF_LAST) begin
                  shift[bit_cnt] <= data_s;
                  state          <= HIGH;
                  snes_clk       <= 1'b1;
                  phase_cnt      <= '0;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (phase_cnt == HALF_LAST) begin
                  phase_cnt <= '0;
                  if (bit_cnt == 4'd15) begin
                     state       <= IDLE;
                     busy        <= 1'b0;
                     snes_button <= ~shift[11:0];
                     snes_id     <= ~shift[15:12];
                     frame_done  <= 1'b1;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     state    <= LOW;
                     snes_clk <= 1'b0;
                  end
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snes_pad_poller.sv
// tb/tb_snes_pad_poller.sv - scoreboard bench for snes_pad_poller
// Pad model serves pad_press (1 = pressed); monitor pops expected {id,button} on each frame_done.
module tb_snes_pad_poller;

   logic        clk = 1'b0;
   logic        rst;
   logic        poll_en;
   logic        snes_data;
   logic        snes_latch;
   logic        snes_clk;
   logic [11:0] snes_button;
   logic [3:0]  snes_id;
   logic        frame_done;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] pad_press = 16'h0000;
   logic [4:0]  pad_idx   = 5'd0;
   logic        pad_prev_clk = 1'b1;
   int          mc = 0;
   logic [15:0] exp_q[$];

   snes_pad_poller #(
      .LATCH_CYC(4),
      .HALF_CYC(4),
      .POLL_PERIOD(200)
   ) dut (
      .clk(clk),
      .rst(rst),
      .poll_en(poll_en),
      .snes_data(snes_data),
      .snes_latch(snes_latch),
      .snes_clk(snes_clk),
      .snes_button(snes_button),
      .snes_id(snes_id),
      .frame_done(frame_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Pad: latch reloads bit 0, each rising snes_clk advances to the next serial bit
   always @(posedge clk) begin
      pad_prev_clk <= snes_clk;
      if (snes_latch)
         pad_idx <= 5'd0;
      else if (snes_clk && !pad_prev_clk && pad_idx < 5'd16)
         pad_idx <= pad_idx + 5'd1;
   end
   assign snes_data = (pad_idx < 5'd16) ? ~pad_press[pad_idx[3:0]] : 1'b0;

   always @(posedge clk) begin
      if (rst)
         mc <= 0;
      else
         mc <= (mc == 199) ? 0 : mc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor
   initial begin
      int          lat_cnt   = 0;
      int          pulse_cnt = 0;
      logic        prev_sclk = 1'b1;
      logic [15:0] last_pub  = 16'h0000;
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            lat_cnt   = 0;
            pulse_cnt = 0;
            prev_sclk = 1'b1;
            last_pub  = 16'h0000;
         end else begin
            if (snes_latch) lat_cnt++;
            if (prev_sclk && !snes_clk) pulse_cnt++;
            prev_sclk = snes_clk;
            if (frame_done) begin
               check("pending_expect_at_frame_done", exp_q.size(), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("button", snes_button, e[11:0]);
                  check("id", snes_id, e[15:12]);
                  last_pub = e;
               end
               check("latch_cycles", lat_cnt, 4);
               check("clk_pulses", pulse_cnt, 16);
               lat_cnt   = 0;
               pulse_cnt = 0;
            end else begin
               check("hold", {snes_id, snes_button}, last_pub);
            end
         end
      end
   end

   task automatic wait_done(input string name);
      logic got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         got = frame_done;
      end
      check({name, "_frame_done_seen"}, got, 1);
   endtask

   task automatic wait_latch(input string name);
      logic got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         got = snes_latch;
      end
      check({name, "_latch_seen"}, got, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      rst     = 1'b1;
      poll_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_latch", snes_latch, 0);
      check("rst_clk", snes_clk, 1);
      check("rst_button", snes_button, 12'h000);
      check("rst_id", snes_id, 4'h0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);

      // 1: nothing pressed, frame starts right after reset
      pad_press = 16'h0000;
      exp_q.push_back(16'h0000);
      rst = 1'b0;
      wait_latch("t1");
      check("t1_busy", busy, 1);
      check("t1_first_frame_immediate", mc, 1);
      wait_done("t1");
      check("t1_idle_after", busy, 0);

      // 2: B and R
      pad_press = 16'h0801;
      exp_q.push_back(16'h0801);
      wait_done("t2");

      // 3: directions, then release
      pad_press = 16'h00F0;
      exp_q.push_back(16'h00F0);
      wait_done("t3a");
      pad_press = 16'h0000;
      exp_q.push_back(16'h0000);
      wait_done("t3b");

      // 6: ID nibble bits low; poll_en drops mid-frame, frame still completes
      pad_press = 16'hF000;
      exp_q.push_back(16'hF000);
      wait_latch("t6");
      repeat (20) @(negedge clk);
      poll_en = 1'b0;
      wait_done("t6");

      // 4: disabled for 1000 cycles, then re-enable mid-period
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         check("t4_latch_idle", snes_latch, 0);
         check("t4_clk_idle", snes_clk, 1);
         check("t4_busy_idle", busy, 0);
      end
      pad_press = 16'h0A5C;
      exp_q.push_back(16'h0A5C);
      got = 1'b0;
      for (int n = 0; n < 250 && !got; n++) begin
         @(negedge clk);
         got = (mc == 100);
      end
      check("t4_mid_period_reached", got, 1);
      poll_en = 1'b1;
      wait_latch("t4");
      check("t4_latch_at_wrap", mc, 1);
      wait_done("t4");

      // 5: reset 50 cycles into a frame
      pad_press = 16'hFFFF;
      wait_latch("t5");
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_latch", snes_latch, 0);
      check("t5_clk", snes_clk, 1);
      check("t5_busy", busy, 0);
      check("t5_button", snes_button, 12'h000);
      check("t5_id", snes_id, 4'h0);
      check("t5_frame_done", frame_done, 0);
      repeat (2) @(negedge clk);
      exp_q.push_back(16'hFFFF);
      rst = 1'b0;
      wait_done("t5");

      poll_en = 1'b0;
      repeat (300) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
